// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1 TAP controller with a 4-bit instruction
// register, 32-bit ID register, 1-bit bypass register and an external
// boundary-scan register interface.
//
// Ports:
//   clk        test clock (state changes on the rising edge)
//   trst_n     asynchronous active-low test reset
//   tms, tdi   test mode select / serial data in (sampled on rising edge)
//   tdo        serial data out (updated on the falling edge)
//   tdo_en     tdo driven, high in Shift-IR / Shift-DR (falling edge)
//   bsr_tdo    serial output of the external boundary-scan register
//   shift_dr   boundary-register shift enable    (EXTEST / SAMPLE_PRELOAD)
//   capture_dr boundary-register capture enable  (EXTEST / SAMPLE_PRELOAD)
//   update_dr  boundary-register update strobe   (EXTEST / SAMPLE_PRELOAD)
//   mode       boundary-cell output mode, high while instruction is EXTEST
//   tlr        high while the FSM is in Test-Logic-Reset
module tap_controller #(
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic clk,
  input  logic trst_n,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  input  logic bsr_tdo,
  output logic shift_dr,
  output logic capture_dr,
  output logic update_dr,
  output logic mode,
  output logic tlr
);

  // Bit 0 of an IEEE ID code is always 1.
  localparam logic [31:0] ID_VALUE = {IDCODE[31:1], 1'b1};

  localparam logic [3:0] INSTR_EXTEST  = 4'b0000;
  localparam logic [3:0] INSTR_SAMPLE  = 4'b0001;
  localparam logic [3:0] INSTR_IDCODE  = 4'b0010;
  localparam logic [3:0] IR_CAPTURE    = 4'b0101;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ir_sr_q, ir_sr_d;
  logic [3:0]  instr_q, instr_d;
  logic [31:0] id_q, id_d;
  logic        byp_q, byp_d;
  logic        capture_q, capture_d;
  logic        shift_q, shift_d;
  logic        update_q, update_d;
  logic        tdo_q, tdo_d;
  logic        tdo_en_q, tdo_en_d;
  logic        bsr_sel;
  logic        dr_bit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms ? TLR      : RTI;
      RTI:      state_d = tms ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tms ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tms ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tms ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tms ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tms ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tms ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Boundary register is in the DR path only for EXTEST / SAMPLE_PRELOAD.
  assign bsr_sel = (instr_q == INSTR_EXTEST) || (instr_q == INSTR_SAMPLE);

  always_comb begin
    if (bsr_sel)                     dr_bit = bsr_tdo;
    else if (instr_q == INSTR_IDCODE) dr_bit = id_q[0];
    else                             dr_bit = byp_q;
  end

  // Shift registers are only touched in Capture/Shift; Pause and Exit hold.
  always_comb begin
    ir_sr_d = ir_sr_q;
    instr_d = instr_q;
    id_d    = id_q;
    byp_d   = byp_q;
    case (state_q)
      CAP_IR: ir_sr_d = IR_CAPTURE;
      SH_IR:  ir_sr_d = {tdi, ir_sr_q[3:1]};
      UPD_IR: instr_d = ir_sr_q;
      CAP_DR: begin
        id_d  = ID_VALUE;
        byp_d = 1'b0;
      end
      SH_DR: begin
        id_d  = {tdi, id_q[31:1]};
        byp_d = tdi;
      end
      default: ;
    endcase
    if (state_d == TLR) instr_d = INSTR_IDCODE;
  end

  // Strobes are flop decodes of the current state, so they trail the
  // state by one clock and carry no path from tms.
  always_comb begin
    capture_d = bsr_sel && (state_q == CAP_DR);
    shift_d   = bsr_sel && (state_q == SH_DR);
    update_d  = bsr_sel && (state_q == UPD_DR);
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_sr_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_d    = dr_bit;
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      state_q   <= TLR;
      ir_sr_q   <= IR_CAPTURE;
      instr_q   <= INSTR_IDCODE;
      id_q      <= ID_VALUE;
      byp_q     <= 1'b0;
      capture_q <= 1'b0;
      shift_q   <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_sr_q   <= ir_sr_d;
      instr_q   <= instr_d;
      id_q      <= id_d;
      byp_q     <= byp_d;
      capture_q <= capture_d;
      shift_q   <= shift_d;
      update_q  <= update_d;
    end
  end

  always_ff @(negedge clk or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign capture_dr = capture_q;
  assign shift_dr   = shift_q;
  assign update_dr  = update_q;
  // Single-register decodes: follow trst_n and TLR entry without delay.
  assign mode       = (instr_q == INSTR_EXTEST);
  assign tlr        = (state_q == TLR);

endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: randomized and directed checks of tap_controller
// against a behavioural TAP model held in the bench.
module tb_tap_controller;

  localparam logic [31:0] ID = 32'h4BA0_0477;

  // Model state numbering; Capture..Update of each column are consecutive.
  localparam int S_TLR = 0, S_RTI = 1, S_SELDR = 2, S_CAPDR = 3;
  localparam int S_SHDR = 4, S_UPDDR = 8, S_SELIR = 9, S_CAPIR = 10;
  localparam int S_SHIR = 11;

  logic clk = 1'b0;
  logic trst_n = 1'b1;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic bsr_tdo = 1'b0;
  logic tdo, tdo_en, shift_dr, capture_dr, update_dr, mode, tlr;

  int n_tests = 0;
  int n_fail  = 0;

  // Model contents
  int          ms;
  logic [3:0]  m_ir, m_instr;
  logic [31:0] m_id;
  logic        m_byp, m_tdo, m_en, m_cap, m_sh, m_upd;

  tap_controller #(.IDCODE(ID)) dut (
    .clk(clk), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo),
    .tdo_en(tdo_en), .bsr_tdo(bsr_tdo), .shift_dr(shift_dr),
    .capture_dr(capture_dr), .update_dr(update_dr), .mode(mode), .tlr(tlr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transition rules written column-wise: position within Capture..Update.
  function automatic int next_state(input int s, input logic t);
    int base, k;
    case (s)
      S_TLR:   return t ? S_TLR   : S_RTI;
      S_RTI:   return t ? S_SELDR : S_RTI;
      S_SELDR: return t ? S_SELIR : S_CAPDR;
      S_SELIR: return t ? S_TLR   : S_CAPIR;
      default: ;
    endcase
    base = (s >= S_CAPIR) ? S_CAPIR : S_CAPDR;
    k = s - base;  // 0 cap,1 shift,2 exit1,3 pause,4 exit2,5 update
    case (k)
      0, 1:    return base + (t ? 2 : 1);
      2:       return base + (t ? 5 : 3);
      3:       return base + (t ? 4 : 3);
      4:       return base + (t ? 5 : 1);
      default: return t ? S_SELDR : S_RTI;
    endcase
  endfunction

  function automatic logic is_bsr_instr(input logic [3:0] i);
    return (i == 4'b0000) || (i == 4'b0001);
  endfunction

  task automatic model_reset();
    ms = S_TLR; m_ir = 4'b0101; m_instr = 4'b0010; m_id = ID; m_byp = 1'b0;
    m_tdo = 1'b0; m_en = 1'b0; m_cap = 1'b0; m_sh = 1'b0; m_upd = 1'b0;
  endtask

  task automatic model_rise(input logic t, input logic d);
    m_cap = is_bsr_instr(m_instr) && (ms == S_CAPDR);
    m_sh  = is_bsr_instr(m_instr) && (ms == S_SHDR);
    m_upd = is_bsr_instr(m_instr) && (ms == S_UPDDR);
    if (ms == S_CAPIR) m_ir = 4'b0101;
    if (ms == S_SHIR)  m_ir = {d, m_ir[3:1]};
    if (ms == S_UPDIR_f()) m_instr = m_ir;
    if (ms == S_CAPDR) begin m_id = ID; m_byp = 1'b0; end
    if (ms == S_SHDR)  begin m_id = {d, m_id[31:1]}; m_byp = d; end
    ms = next_state(ms, t);
    if (ms == S_TLR) m_instr = 4'b0010;
  endtask

  function automatic int S_UPDIR_f();
    return S_CAPIR + 5;
  endfunction

  task automatic model_fall();
    m_en = (ms == S_SHIR) || (ms == S_SHDR);
    if (ms == S_SHIR)      m_tdo = m_ir[0];
    else if (ms == S_SHDR) m_tdo = is_bsr_instr(m_instr) ? bsr_tdo :
                                   (m_instr == 4'b0010) ? m_id[0] : m_byp;
    else                   m_tdo = 1'b0;
  endtask

  task automatic check_all();
    check("tdo", tdo, m_tdo);
    check("tdo_en", tdo_en, m_en);
    check("capture_dr", capture_dr, m_cap);
    check("shift_dr", shift_dr, m_sh);
    check("update_dr", update_dr, m_upd);
    check("mode", mode, m_instr == 4'b0000);
    check("tlr", tlr, ms == S_TLR);
  endtask

  task automatic step(input logic t, input logic d);
    tms = t; tdi = d; bsr_tdo = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_rise(t, d);
    @(negedge clk);
    model_fall();
    #1 check_all();
  endtask

  // Asynchronous reset asserted in the low phase of clk.
  task automatic do_reset();
    trst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 trst_n = 1'b1;
  endtask

  // Called in a Shift state: observes n bits, performs n shifts, exits to Exit1.
  task automatic scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    dout[0] = tdo;
    for (int i = 1; i < n; i++) begin
      step(1'b0, din[i-1]);
      dout[i] = tdo;
    end
    step(1'b1, din[n-1]);
  endtask

  task automatic enter_shdr();  // from RTI
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic ir_load(input logic [3:0] v, output logic [3:0] cap);
    logic [31:0] o;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    scan(4, {28'b0, v}, o);
    cap = o[3:0];
    step(1'b1, 1'b0);  // Update-IR
    step(1'b0, 1'b0);  // Run-Test/Idle
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  c;
    #1 do_reset();

    // ID scan straight out of reset
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    scan(32, $urandom, a);
    check("idcode_scan", a, ID);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // EXTEST load, boundary path, then async reset mid-shift
    ir_load(4'b0000, c);
    check("ir_capture", c, 4'b0101);
    check("mode_extest", mode, 1'b1);
    enter_shdr();
    step(1'b0, 1'b1);
    check("shift_dr_extest", shift_dr, 1'b1);
    step(1'b0, 1'b0);
    do_reset();
    check("mode_after_trst", mode, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // BYPASS
    ir_load(4'b1111, c);
    enter_shdr();
    scan(4, 32'hD, a);
    check("bypass_tdo", a[3:0], 4'b1010);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // Pause / resume during ID scan
    ir_load(4'b0010, c);
    enter_shdr();
    scan(8, $urandom, a);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    scan(24, $urandom, b);
    check("pause_resume", {b[23:0], a[7:0]}, ID);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // Five tms=1 clocks from Pause-IR under EXTEST
    ir_load(4'b0000, c);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms_reset_tlr", tlr, 1'b1);
    check("tms_reset_mode", mode, 1'b0);

    // Random walk
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter IDCODE, default 32'h1000_0001: 32-bit value for the device ID register; bit 0 SHALL be 1.
REQ-002 Port clk  input  1: test clock; all state changes occur on the rising edge unless stated otherwise.
REQ-003 Port trst_n  input  1: test reset; asynchronous, active-low.
REQ-004 Port tms  input  1: test mode select, sampled on the rising edge of clk.
REQ-005 Port tdi  input  1: serial data in; passed to the selected register.
REQ-006 Port tdo  output  1: serial data out; changes on the falling edge of clk.
REQ-007 Port tdo_en  output  1: tdo valid or driven; changes on the falling edge of clk.
REQ-008 Port bsr_tdo  input  1: serial output of the external boundary-scan register.
REQ-009 Port shift_dr  output  1: boundary-register shift enable.
REQ-010 Port capture_dr  output  1: boundary-register capture enable.
REQ-011 Port update_dr  output  1: boundary-register update strobe.
REQ-012 Port mode  output  1: boundary-cell output mode; 1 while the current instruction is EXTEST.
REQ-013 Port tlr  output  1: high while the FSM is in Test-Logic-Reset.

Function
REQ-014 The FSM SHALL implement the 16 IEEE 1149.1 TAP states, with transitions taken on the rising edge of clk on the value of tms:
- TLR: 0 -> RTI; 1 -> TLR
- RTI: 0 -> RTI; 1 -> SelDR
- SelDR: 0 -> CapDR; 1 -> SelIR
- SelIR: 0 -> CapIR; 1 -> TLR
- CapX: 0 -> ShX; 1 -> Ex1X
- ShX: 0 -> ShX; 1 -> Ex1X
- Ex1X: 0 -> PauseX; 1 -> UpdX
- PauseX: 0 -> PauseX; 1 -> Ex2X
- Ex2X: 0 -> ShX; 1 -> UpdX
- UpdX: 0 -> RTI; 1 -> SelDR
(X = DR or IR.)
REQ-015 From any state, five consecutive clk rising edges with tms=1 SHALL reach TLR.
REQ-016 All registered outputs SHALL be decoded from the state register and the instruction register only, with no combinational path from tms.
REQ-017 IR SHALL be 4 bits wide with these encodings:
- EXTEST = 4'b0000
- SAMPLE_PRELOAD = 4'b0001
- IDCODE = 4'b0010
- BYPASS = 4'b1111
- every other code behaves as BYPASS
REQ-018 In CapIR, the IR shift register SHALL load 4'b0101.
REQ-019 In ShIR, the IR shift register SHALL shift right, with tdi entering the MSB and the LSB going to tdo.
REQ-020 On the rising edge leaving UpdIR, the current instruction SHALL load from the IR shift register.
REQ-021 The DR path SHALL be selected by the current instruction:
- EXTEST and SAMPLE_PRELOAD select bsr_tdo.
- IDCODE selects a 32-bit ID register.
- All other codes select a 1-bit bypass register.
REQ-022 The ID register SHALL load IDCODE in CapDR and shift right in ShDR, with tdi entering bit 31 and bit 0 going out.
REQ-023 The bypass register SHALL load 0 in CapDR and load tdi in ShDR.
REQ-024 capture_dr SHALL be 1 only in CapDR; shift_dr SHALL be 1 only in ShDR; update_dr SHALL be 1 only in UpdDR; these apply only when the current instruction is EXTEST or SAMPLE_PRELOAD, and each is 0 otherwise.
REQ-025 update_dr rising SHALL occur one clk after entry into UpdDR and SHALL be glitch-free, being driven from a flop.
REQ-026 On the falling edge of clk, tdo SHALL take the selected serial bit and tdo_en SHALL be set to 1, in both ShIR and ShDR.
REQ-027 In all other states, on the falling edge of clk, tdo_en SHALL be 0 and tdo SHALL be 0.
REQ-028 Pause and Exit states SHALL hold all shift register contents unchanged.
REQ-029 A new instruction SHALL affect the DR path select and mode only after UpdIR, never during ShIR.

Reset
REQ-030 trst_n=0 SHALL immediately force:
- state to TLR
- current instruction to IDCODE
- IR shift register to 4'b0101
- ID register to IDCODE
- bypass register to 0
- tdo, tdo_en, shift_dr, capture_dr, update_dr and mode to 0
- tlr to 1
REQ-031 Entry into TLR via tms SHALL also set the current instruction to IDCODE on that edge.
REQ-032 Assertion of trst_n mid-shift SHALL abort the scan with no update_dr pulse, and mode SHALL fall to 0 asynchronously.

Verification
REQ-033 Reset then DR scan: trst_n pulse; tms 0,1,0,0; 32 ShDR clocks -> tdo sequence = IDCODE LSB first; the first tdo bit appears after the falling edge in ShDR.
REQ-034 IR load EXTEST: scan 4'b0000 via ShIR -> captured output bits read 1,0,1,0; after UpdIR, mode=1; in a later ShDR, tdo follows bsr_tdo and shift_dr=1.
REQ-035 BYPASS: load 4'b1111; shift pattern 1,0,1,1 in ShDR -> tdo = 0,1,0,1 (one-cycle delay, leading 0); shift_dr stays 0.
REQ-036 Pause/resume: ShDR 8 bits, Ex1DR, PauseDR x3, Ex2DR, ShDR -> the ID stream continues at bit 8 with no lost or duplicated bits.
REQ-037 TMS-high reset: from PauseIR, apply tms=1 for 5 clocks -> tlr=1, instruction = IDCODE, mode=0.
REQ-038 Async reset: assert trst_n during ShDR under EXTEST -> all outputs reset within the same cycle, and update_dr never pulses.
